// File: rtl/sysid_check_ctrl.sv
// Reads the sysid slave (word 0 = ID, word 1 = build timestamp), compares both words
// against expected values and reports match flags plus a saturating mismatch count.
// Optional periodic self-recheck is enabled by defining SYSID_CHECK_PERIODIC_EN.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1392333275,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned RECHECK_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        match,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  err_count,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD_ID = 2'd1,
        S_RD_TS = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAT = 4'(READ_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        match_q, match_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;
    logic [7:0]  err_q, err_d;
    logic        addr_q, addr_d;
    logic        auto_start_s;
    logic        start_s;
    logic        id_eq_s;
    logic        ts_eq_s;

`ifdef SYSID_CHECK_PERIODIC_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // Auto-start fires once the idle counter has spent RECHECK_CYCLES cycles in IDLE.
    always_comb begin
        auto_start_s = (state_q == S_IDLE) && (idle_cnt_q == 32'(RECHECK_CYCLES - 1));
        if ((state_q == S_IDLE) && !(start || auto_start_s)) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end else begin
            idle_cnt_d = 32'd0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_q <= 32'd0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign auto_start_s = 1'b0;
`endif

    assign start_s = start | auto_start_s;
    assign id_eq_s = (cap_id_q == EXPECTED_ID);
    assign ts_eq_s = (cap_ts_q == EXPECTED_TS);

    // Next-state and registered-output logic for the read sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        valid_d  = valid_q;
        id_ok_d  = id_ok_q;
        ts_ok_d  = ts_ok_q;
        match_d  = match_q;
        cap_id_d = cap_id_q;
        cap_ts_d = cap_ts_q;
        err_d    = err_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                addr_d = 1'b0;
                if (start_s) begin
                    state_d = S_RD_ID;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ID: begin
                if (cnt_q == LAT) begin
                    cap_id_d = sysid_readdata;
                    cnt_d    = 4'd0;
                    addr_d   = 1'b1;
                    state_d  = S_RD_TS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_TS: begin
                if (cnt_q == LAT) begin
                    cap_ts_d = sysid_readdata;
                    cnt_d    = 4'd0;
                    addr_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // Results become visible the cycle after the done pulse and hold until the next DONE.
                id_ok_d = id_eq_s;
                ts_ok_d = ts_eq_s;
                match_d = id_eq_s & ts_eq_s;
                valid_d = 1'b1;
                if (!(id_eq_s & ts_eq_s) && (err_q != 8'd255)) begin
                    err_d = err_q + 8'd1;
                end else begin
                    err_d = err_q;
                end
                busy_d  = 1'b0;
                addr_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                addr_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            match_q  <= 1'b0;
            cap_id_q <= 32'd0;
            cap_ts_q <= 32'd0;
            err_q    <= 8'd0;
            addr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            id_ok_q  <= id_ok_d;
            ts_ok_q  <= ts_ok_d;
            match_q  <= match_d;
            cap_id_q <= cap_id_d;
            cap_ts_q <= cap_ts_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign valid         = valid_q;
    assign id_ok         = id_ok_q;
    assign ts_ok         = ts_ok_q;
    assign match         = match_q;
    assign captured_id   = cap_id_q;
    assign captured_ts   = cap_ts_q;
    assign err_count     = err_q;
    assign sysid_address = addr_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Scoreboard bench for sysid_check_ctrl: one instance with READ_LATENCY=0 and one with
// READ_LATENCY=2 behind a 2-cycle delayed slave.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1392333275;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        id_ok;
        logic        ts_ok;
        logic        match;
        logic [7:0]  err;
        int          done_cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   err_m[2];
    exp_t q0[$];
    exp_t q2[$];

    logic        start0, busy0, done0, valid0, id_ok0, ts_ok0, match0, addr0;
    logic [31:0] cid0, cts0, rdata0, id0, ts0;
    logic [7:0]  err0;
    logic        start2, busy2, done2, valid2, id_ok2, ts_ok2, match2, addr2;
    logic [31:0] cid2, cts2, rdata2, id2, ts2;
    logic [7:0]  err2;
    logic        a2_d1 = 1'b0;
    logic        a2_d2 = 1'b0;
    logic        last_match0 = 1'b0;
    logic        last_match2 = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign rdata0 = addr0 ? ts0 : id0;
    always @(posedge clock) begin
        a2_d1 <= addr2;
        a2_d2 <= a2_d1;
    end
    assign rdata2 = a2_d2 ? ts2 : id2;

    sysid_check_ctrl #(.READ_LATENCY(0), .RECHECK_CYCLES(8)) u_dut0 (
        .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .valid(valid0), .id_ok(id_ok0), .ts_ok(ts_ok0), .match(match0),
        .captured_id(cid0), .captured_ts(cts0), .err_count(err0),
        .sysid_address(addr0), .sysid_readdata(rdata0));

    sysid_check_ctrl #(.READ_LATENCY(2), .RECHECK_CYCLES(8)) u_dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .valid(valid2), .id_ok(id_ok2), .ts_ok(ts_ok2), .match(match2),
        .captured_id(cid2), .captured_ts(cts2), .err_count(err2),
        .sysid_address(addr2), .sysid_readdata(rdata2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int which, input logic [31:0] id, input logic [31:0] ts,
                            input int dcyc);
        exp_t e;
        e.id    = id;
        e.ts    = ts;
        e.id_ok = (id == EXP_ID);
        e.ts_ok = (ts == EXP_TS);
        e.match = e.id_ok && e.ts_ok;
        if (!e.match && err_m[which] < 255) err_m[which]++;
        e.err      = 8'(err_m[which]);
        e.done_cyc = dcyc;
        if (which == 0) q0.push_back(e);
        else q2.push_back(e);
    endtask

    // Called at a negedge: start sampled this cycle, done expected 3 cycles later.
    task automatic pulse0(input logic [31:0] id, input logic [31:0] ts);
        id0    = id;
        ts0    = ts;
        start0 = 1'b1;
        push_exp(0, id, ts, cyc + 3);
        @(negedge clock);
        start0 = 1'b0;
    endtask

    // READ_LATENCY=2: address low for 3 cycles, high for 3, low again at DONE (cycle +7).
    task automatic pulse2(input logic [31:0] id, input logic [31:0] ts);
        id2    = id;
        ts2    = ts;
        start2 = 1'b1;
        push_exp(1, id, ts, cyc + 7);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            start2 = 1'b0;
            check("d2_address_trace", addr2, 32'((i >= 4) && (i <= 6)));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (q0.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q2.size());
            q0.delete();
            q2.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    // Monitor for the READ_LATENCY=0 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d0_unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e = q0.pop_front();
                    check("d0_latency", 32'(cyc), 32'(e.done_cyc));
                    check("d0_captured_id", cid0, e.id);
                    check("d0_captured_ts", cts0, e.ts);
                    check("d0_match_held", match0, last_match0);
                    @(negedge clock);
                    check("d0_id_ok", id_ok0, e.id_ok);
                    check("d0_ts_ok", ts_ok0, e.ts_ok);
                    check("d0_match", match0, e.match);
                    check("d0_valid", valid0, 1'b1);
                    check("d0_err_count", err0, e.err);
                    last_match0 = e.match;
                end
            end
        end
    end

    // Monitor for the READ_LATENCY=2 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d2_unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
                end else begin
                    e = q2.pop_front();
                    check("d2_latency", 32'(cyc), 32'(e.done_cyc));
                    check("d2_captured_id", cid2, e.id);
                    check("d2_captured_ts", cts2, e.ts);
                    check("d2_match_held", match2, last_match2);
                    @(negedge clock);
                    check("d2_id_ok", id_ok2, e.id_ok);
                    check("d2_ts_ok", ts_ok2, e.ts_ok);
                    check("d2_match", match2, e.match);
                    check("d2_valid", valid2, 1'b1);
                    check("d2_err_count", err2, e.err);
                    last_match2 = e.match;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic any_busy;
        int   n;
        reset  = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        id0 = EXP_ID; ts0 = EXP_TS;
        id2 = EXP_ID; ts2 = EXP_TS;
        err_m[0] = 0;
        err_m[1] = 0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);
        check("rst_valid", valid0, 1'b0);
        check("rst_flags", {29'd0, id_ok0, ts_ok0, match0}, 32'd0);
        check("rst_captured_id", cid0, 32'd0);
        check("rst_captured_ts", cts0, 32'd0);
        check("rst_err_count", err0, 8'd0);
        check("rst_address", addr0, 1'b0);
        check("rst_d2_outputs", {valid2, busy2, done2, addr2, err2}, 32'd0);
        reset = 1'b0;

        // No start: no check may run in the default build.
        any_busy = 1'b0;
        repeat (20) begin
            @(negedge clock);
            any_busy = any_busy | busy0 | busy2;
        end
        check("no_start_no_activity", any_busy, 1'b0);

        // Matching slave, then ID mismatch.
        pulse0(EXP_ID, EXP_TS);
        drain();
        pulse0(32'h0000_0001, EXP_TS);
        drain();

        // Delayed slave with READ_LATENCY=2: match, then timestamp mismatch.
        pulse2(EXP_ID, EXP_TS);
        drain();
        pulse2(EXP_ID, 32'h1234_5678);
        drain();

        // Start toggled while busy must not queue a second check.
        id0 = EXP_ID;
        ts0 = EXP_TS;
        push_exp(0, EXP_ID, EXP_TS, cyc + 3);
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        @(negedge clock); start0 = 1'b1;
        @(negedge clock); start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        repeat (8) @(negedge clock);
        drain();

        // Start held high against a mismatching slave: err_count saturates at 255.
        id0 = 32'hDEAD_BEEF;
        for (int k = 0; k < 300; k++) push_exp(0, id0, ts0, cyc + 3 + 4 * k);
        start0 = 1'b1;
        n = 0;
        while (q0.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        start0 = 1'b0;
        drain();
        check("saturated_err_count", err0, 8'd255);

        // Reset while in RD_TS aborts without a done pulse.
        id0 = EXP_ID;
        ts0 = EXP_TS;
        start0 = 1'b1;
        @(negedge clock); start0 = 1'b0;
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_valid", valid0, 1'b0);
        check("abort_flags", {29'd0, id_ok0, ts_ok0, match0}, 32'd0);
        check("abort_captured", cid0 | cts0, 32'd0);
        check("abort_err_count", err0, 8'd0);
        check("abort_address", addr0, 1'b0);
        reset = 1'b0;
        err_m[0] = 0;
        err_m[1] = 0;
        last_match0 = 1'b0;
        last_match2 = 1'b0;
        repeat (5) @(negedge clock);
        check("abort_still_idle", busy0, 1'b0);
        pulse0(EXP_ID, EXP_TS);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
